// File: rtl/buffer_rr_arbiter_pkg.sv
// Shared types and helpers for round-robin arbiters feeding a single-entry buffer.
package buffer_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } arb_state_e;

  localparam int MaxReq        = 16;
  localparam int NumReqDefault = 4;
  localparam int IdWidth       = $clog2(NumReqDefault);

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of valid[n-1:0] searching upward from ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                       input logic [3:0]        ptr,
                                       input int                n);
    rr_pick_t r;
    int       cand;
    r = '0;
    for (int k = 0; k < MaxReq; k++) begin
      cand = int'(ptr) + k;
      if (cand >= n) cand = cand - n;
      if (k < n && !r.found && valid[cand[3:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/buffer_rr_arbiter_if.sv
// Requester / buffer-write bundle of buffer_rr_arbiter. ReqLock exists only with BUFFER_RR_ARBITER_LOCK_EN.
interface buffer_rr_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 64
);
  logic [NumReq-1:0]           ReqValid;
  logic [NumReq*DataWidth-1:0] ReqData;
  logic [NumReq-1:0]           ReqReady;
  logic [DataWidth-1:0]        BufWData;
  logic                        BufWInc;
  logic                        BufWFull;
  logic                        Jump;
  logic [$clog2(NumReq)-1:0]   GrantId;
  logic                        Busy;
`ifdef BUFFER_RR_ARBITER_LOCK_EN
  logic [NumReq-1:0]           ReqLock;

  modport master (output ReqValid, ReqData, BufWFull, Jump, ReqLock,
                  input  ReqReady, BufWData, BufWInc, GrantId, Busy);
  modport slave  (input  ReqValid, ReqData, BufWFull, Jump, ReqLock,
                  output ReqReady, BufWData, BufWInc, GrantId, Busy);
`else
  modport master (output ReqValid, ReqData, BufWFull, Jump,
                  input  ReqReady, BufWData, BufWInc, GrantId, Busy);
  modport slave  (input  ReqValid, ReqData, BufWFull, Jump,
                  output ReqReady, BufWData, BufWInc, GrantId, Busy);
`endif
endinterface

// File: rtl/buffer_rr_arbiter_picker.sv
// rr_priority_picker: combinational rotate-and-priority-encode of NumReq request bits from a pointer.
module rr_priority_picker
  import buffer_arb_pkg::*;
#(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]         valid_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic                      found_o,
  output logic [$clog2(NumReq)-1:0] idx_o
);
  localparam int IdW = $clog2(NumReq);

  logic [MaxReq-1:0] valid_ext;
  rr_pick_t          pick;

  for (genvar gi = 0; gi < MaxReq; gi++) begin : g_ext
    if (gi < NumReq) begin : g_used
      assign valid_ext[gi] = valid_i[gi];
    end else begin : g_pad
      assign valid_ext[gi] = 1'b0;
    end
  end

  assign pick    = rr_pick(valid_ext, 4'(ptr_i), NumReq);
  assign found_o = pick.found;
  assign idx_o   = IdW'(pick.idx);
endmodule

// File: rtl/buffer_rr_arbiter.sv
// Round-robin arbiter into a one-deep stage driving a shared buffer write port, with Jump flush window.
// Optional requester lock: define BUFFER_RR_ARBITER_LOCK_EN.
module buffer_rr_arbiter
  import buffer_arb_pkg::*;
#(
  parameter int NumReq      = 4,
  parameter int DataWidth   = 64,
  parameter int FlushCycles = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  buffer_rr_arbiter_if.slave bus
);
  localparam int                IdW       = $clog2(NumReq);
  localparam int                CntW      = 4;
  localparam logic [IdW-1:0]    LastId    = IdW'(NumReq - 1);
  localparam logic [CntW-1:0]   FlushLast = CntW'(FlushCycles - 1);

  arb_state_e           state_q, state_d;
  logic [CntW-1:0]      flush_cnt_q, flush_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]       grant_id_q, grant_id_d;

  logic                 pick_found;
  logic [IdW-1:0]       pick_idx;
  logic                 win_found;
  logic [IdW-1:0]       win_idx;
  logic                 stage_free, buf_winc, grant_en, accept;
  logic [DataWidth-1:0] win_data;

  rr_priority_picker #(.NumReq(NumReq)) u_picker (
    .valid_i (bus.ReqValid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

`ifdef BUFFER_RR_ARBITER_LOCK_EN
  logic           locked_q, locked_d;
  logic [IdW-1:0] lock_id_q, lock_id_d;

  // A locked requester owns the grant even while it has nothing to send.
  assign win_found = locked_q || pick_found;
  assign win_idx   = locked_q ? lock_id_q : pick_idx;
`else
  assign win_found = pick_found;
  assign win_idx   = pick_idx;
`endif

  assign buf_winc   = out_valid_q && !bus.BufWFull && (state_q == RUN) && !bus.Jump;
  assign stage_free = !out_valid_q || buf_winc;
  // Rst gates the grant so ReqReady drops the moment reset is asserted.
  assign grant_en   = !Rst && (state_q == RUN) && !bus.Jump && stage_free && win_found;
  assign accept     = grant_en && bus.ReqValid[win_idx];
  assign win_data   = bus.ReqData[int'(win_idx) * DataWidth +: DataWidth];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign bus.ReqReady[gi] = grant_en && (win_idx == IdW'(gi));
  end

  assign bus.BufWInc  = buf_winc;
  assign bus.BufWData = out_data_q;
  assign bus.GrantId  = grant_id_q;
  assign bus.Busy     = out_valid_q || (state_q == FLUSH);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
`ifdef BUFFER_RR_ARBITER_LOCK_EN
    locked_d    = locked_q;
    lock_id_d   = lock_id_q;
`endif

    unique case (state_q)
      RUN: begin
        if (bus.Jump) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (bus.Jump) begin
          flush_cnt_d = '0;
        end else if (flush_cnt_q == FlushLast) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (bus.Jump) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      grant_id_d  = win_idx;
      rr_ptr_d    = (win_idx == LastId) ? '0 : win_idx + 1'b1;
    end else if (buf_winc) begin
      out_valid_d = 1'b0;
    end

`ifdef BUFFER_RR_ARBITER_LOCK_EN
    if (bus.Jump) begin
      locked_d = 1'b0;
    end else if (accept) begin
      locked_d  = bus.ReqLock[win_idx];
      lock_id_d = win_idx;
    end
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
`ifdef BUFFER_RR_ARBITER_LOCK_EN
      locked_q    <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
`ifdef BUFFER_RR_ARBITER_LOCK_EN
      locked_q    <= locked_d;
      lock_id_q   <= lock_id_d;
`endif
    end
  end
endmodule

// File: tb/tb_buffer_rr_arbiter.sv
// Directed bench for buffer_rr_arbiter (NumReq=4, DataWidth=64, FlushCycles=2).
module tb_buffer_rr_arbiter;
  localparam int NumReq    = 4;
  localparam int DataWidth = 64;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  buffer_rr_arbiter_if #(.NumReq(NumReq), .DataWidth(DataWidth)) bus ();

  buffer_rr_arbiter #(
    .NumReq(NumReq), .DataWidth(DataWidth), .FlushCycles(2)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] word [4];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_data(input logic [63:0] base);
    for (int i = 0; i < NumReq; i++) begin
      word[i] = base + 64'(i);
      bus.ReqData[i*DataWidth +: DataWidth] = word[i];
    end
  endtask

  task automatic drive(input logic [3:0] valid, input logic full, input logic jump);
    bus.ReqValid = valid;
    bus.BufWFull = full;
    bus.Jump     = jump;
  endtask

  initial begin
    Rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    bus.ReqData = '0;
`ifdef BUFFER_RR_ARBITER_LOCK_EN
    bus.ReqLock = '0;
`endif
    #2;
    chk_eq("rst_ready", 64'(bus.ReqReady), 64'h0);
    chk_eq("rst_winc",  64'(bus.BufWInc),  64'h0);
    chk_eq("rst_wdata", bus.BufWData,      64'h0);
    chk_eq("rst_busy",  64'(bus.Busy),     64'h0);
    chk_eq("rst_grant", 64'(bus.GrantId),  64'h0);
    tick();
    Rst = 1'b0;

    // All four valid: accepts 0,1,2,3,0 back to back, write one cycle behind.
    set_data(64'hA000);
    drive(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_eq("t1_ready", 64'(bus.ReqReady), 64'(1 << (k % 4)));
      if (k == 0) begin
        chk_eq("t1_winc0", 64'(bus.BufWInc), 64'h0);
      end else begin
        chk_eq("t1_winc",  64'(bus.BufWInc), 64'h1);
        chk_eq("t1_wdata", bus.BufWData,     word[(k - 1) % 4]);
        chk_eq("t1_grant", 64'(bus.GrantId), 64'((k - 1) % 4));
      end
      tick();
    end
    drive(4'b0000, 1'b0, 1'b0);
    #1;
    chk_eq("t1_last_winc",  64'(bus.BufWInc),  64'h1);
    chk_eq("t1_last_wdata", bus.BufWData,      word[0]);
    chk_eq("t1_last_ready", 64'(bus.ReqReady), 64'h0);
    tick();
    #1;
    chk_eq("t1_idle_winc", 64'(bus.BufWInc), 64'h0);
    chk_eq("t1_idle_busy", 64'(bus.Busy),    64'h0);
    tick();

    // Only requester 2 valid: granted every cycle, one write per cycle.
    set_data(64'hB000);
    drive(4'b0100, 1'b0, 1'b0);
    #1;
    chk_eq("t2_ready0", 64'(bus.ReqReady), 64'h4);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk_eq("t2_ready", 64'(bus.ReqReady), 64'h4);
      chk_eq("t2_winc",  64'(bus.BufWInc),  64'h1);
      chk_eq("t2_wdata", bus.BufWData,      word[2]);
      chk_eq("t2_grant", 64'(bus.GrantId),  64'h2);
    end
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    #1;
    chk_eq("t2_drain_winc", 64'(bus.BufWInc), 64'h1);
    tick();
    drive(4'b1111, 1'b0, 1'b0);
    #1;
    chk_eq("t2_ptr3_probe", 64'(bus.ReqReady), 64'h8);
    drive(4'b0000, 1'b0, 1'b0);
    tick();

    // Backpressure: staged word held for 3 full cycles, then written once.
    set_data(64'hC000);
    drive(4'b0011, 1'b0, 1'b0);
    #1;
    chk_eq("t3_ready0", 64'(bus.ReqReady), 64'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(4'b0011, 1'b1, 1'b0);
      #1;
      chk_eq("t3_full_winc",  64'(bus.BufWInc),  64'h0);
      chk_eq("t3_full_ready", 64'(bus.ReqReady), 64'h0);
      chk_eq("t3_full_wdata", bus.BufWData,      word[0]);
    end
    tick();
    drive(4'b0011, 1'b0, 1'b0);
    #1;
    chk_eq("t3_rel_winc",  64'(bus.BufWInc),  64'h1);
    chk_eq("t3_rel_wdata", bus.BufWData,      word[0]);
    chk_eq("t3_rel_ready", 64'(bus.ReqReady), 64'h2);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    #1;
    chk_eq("t3_next_winc",  64'(bus.BufWInc), 64'h1);
    chk_eq("t3_next_wdata", bus.BufWData,     word[1]);
    chk_eq("t3_next_grant", 64'(bus.GrantId), 64'h1);
    tick();
    #1;
    chk_eq("t3_idle_winc", 64'(bus.BufWInc), 64'h0);
    tick();

    // Jump with a staged word: dropped, grants blocked for Jump cycle + 2.
    set_data(64'hD000);
    drive(4'b0001, 1'b0, 1'b0);
    #1;
    chk_eq("t4_ready0", 64'(bus.ReqReady), 64'h1);
    tick();
    drive(4'b0001, 1'b0, 1'b1);
    #1;
    chk_eq("t4_jump_winc",  64'(bus.BufWInc),  64'h0);
    chk_eq("t4_jump_ready", 64'(bus.ReqReady), 64'h0);
    chk_eq("t4_jump_busy",  64'(bus.Busy),     64'h1);
    tick();
    drive(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk_eq("t4_fl_ready", 64'(bus.ReqReady), 64'h0);
      chk_eq("t4_fl_winc",  64'(bus.BufWInc),  64'h0);
      chk_eq("t4_fl_busy",  64'(bus.Busy),     64'h1);
      tick();
    end
    #1;
    chk_eq("t4_run_ready", 64'(bus.ReqReady), 64'h2);
    chk_eq("t4_run_grant", 64'(bus.GrantId),  64'h0);
    chk_eq("t4_run_busy",  64'(bus.Busy),     64'h0);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    #1;
    chk_eq("t4_post_winc",  64'(bus.BufWInc), 64'h1);
    chk_eq("t4_post_wdata", bus.BufWData,     word[1]);
    tick();

    // Asynchronous reset in the middle of a burst.
    set_data(64'hE000);
    drive(4'b1111, 1'b0, 1'b0);
    #1;
    chk_eq("t5_ready0", 64'(bus.ReqReady), 64'h4);
    tick();
    #1;
    chk_eq("t5_winc", 64'(bus.BufWInc), 64'h1);
    #1;
    Rst = 1'b1;
    #1;
    chk_eq("t5_arst_ready", 64'(bus.ReqReady), 64'h0);
    chk_eq("t5_arst_winc",  64'(bus.BufWInc),  64'h0);
    chk_eq("t5_arst_wdata", bus.BufWData,      64'h0);
    chk_eq("t5_arst_busy",  64'(bus.Busy),     64'h0);
    chk_eq("t5_arst_grant", 64'(bus.GrantId),  64'h0);
    @(posedge Clk);
    #2;
    chk_eq("t5_hold_ready", 64'(bus.ReqReady), 64'h0);
    Rst = 1'b0;
    #1;
    chk_eq("t5_rel_ready", 64'(bus.ReqReady), 64'h1);
    tick();
    #1;
    chk_eq("t5_first_grant", 64'(bus.GrantId), 64'h0);
    chk_eq("t5_first_wdata", bus.BufWData,     word[0]);
    drive(4'b0000, 1'b0, 1'b0);
    tick();
    #1;
    chk_eq("t5_idle_busy", 64'(bus.Busy), 64'h0);
    tick();

`ifdef BUFFER_RR_ARBITER_LOCK_EN
    // Requester 1 locks for two accepts: order 1,1,1,2,0; Jump clears a lock.
    set_data(64'hF000);
    drive(4'b0111, 1'b0, 1'b0);
    bus.ReqLock = 4'b0010;
    #1;
    chk_eq("t6_acc0", 64'(bus.ReqReady), 64'h2);
    tick();
    #1;
    chk_eq("t6_acc1", 64'(bus.ReqReady), 64'h2);
    tick();
    bus.ReqLock = 4'b0000;
    #1;
    chk_eq("t6_acc2", 64'(bus.ReqReady), 64'h2);
    tick();
    #1;
    chk_eq("t6_acc3", 64'(bus.ReqReady), 64'h4);
    tick();
    bus.ReqLock = 4'b0001;
    #1;
    chk_eq("t6_acc4", 64'(bus.ReqReady), 64'h1);
    tick();
    drive(4'b0111, 1'b0, 1'b1);
    #1;
    chk_eq("t6_jump_ready", 64'(bus.ReqReady), 64'h0);
    tick();
    drive(4'b0111, 1'b0, 1'b0);
    bus.ReqLock = 4'b0000;
    tick();
    tick();
    #1;
    chk_eq("t6_unlocked", 64'(bus.ReqReady), 64'h2);
    drive(4'b0000, 1'b0, 1'b0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
